// File: rtl/perm_feed_tx.sv
// perm_feed_tx: reads one 25-lane Keccak state from a 5x5 lane memory and streams it as
// 25 words over a pushout/firstout/stopin link. Optional stall counter: PERM_FEED_STALL_CNT_EN.
module perm_feed_tx #(
  parameter int W     = 64,
  parameter int NLANE = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [2:0]   ax,
  output logic [2:0]   ay,
  input  logic [W-1:0] rd,
  output logic         pushout,
  input  logic         stopin,
  output logic         firstout,
`ifdef PERM_FEED_STALL_CNT_EN
  output logic [W-1:0] dout,
  output logic [15:0]  stall_cnt
`else
  output logic [W-1:0] dout
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(NLANE);

  state_t       r_state;
  state_t       w_next;
  logic [4:0]   r_idx;
  logic [2:0]   r_x;
  logic [2:0]   r_y;
  logic [W-1:0] r_dout;
  logic         r_push;
  logic         r_first;
  logic         r_busy;
  logic         r_done;

  logic w_xfer;
  logic w_free;
  logic w_accept;
  logic w_load;
  logic w_drain;
  logic w_finish;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // The output register is free when empty or being emptied this cycle; r_idx counts words loaded.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_drain  = 1'b0;
    w_finish = 1'b0;
    w_xfer   = r_push & ~stopin;
    w_free   = ~r_push | w_xfer;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_SEND;
          w_accept = 1'b1;
        end
      end
      S_SEND: begin
        if (w_free && (r_idx < LAST_CNT)) w_load  = 1'b1;
        else if (w_free)                  w_drain = 1'b1;
        if (w_xfer && (r_idx == LAST_CNT)) begin
          w_next   = S_DONE;
          w_finish = 1'b1;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_dout  <= '0;
      r_push  <= 1'b0;
      r_first <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end
      if (w_finish) r_busy <= 1'b0;
      if (w_load) begin
        r_dout  <= rd;
        r_first <= (r_idx == 5'd0);
        r_push  <= 1'b1;
        r_idx   <= r_idx + 5'd1;
        // After lane (4,4) both counters wrap to 0, so they rest at 0 between frames.
        if (r_x == 3'd4) begin
          r_x <= '0;
          r_y <= (r_y == 3'd4) ? 3'd0 : r_y + 3'd1;
        end else begin
          r_x <= r_x + 3'd1;
        end
      end
      if (w_drain) begin
        r_push  <= 1'b0;
        r_first <= 1'b0;
      end
    end
  end

`ifdef PERM_FEED_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (reset)                                   r_stall <= '0;
    else if (w_accept)                           r_stall <= '0;
    else if (r_push && stopin && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end

  assign stall_cnt = r_stall;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign ax       = r_x;
  assign ay       = r_y;
  assign pushout  = r_push;
  assign firstout = r_first;
  assign dout     = r_dout;

endmodule

// File: tb/tb_perm_feed_tx.sv
// Self-checking bench for perm_feed_tx: a lane memory plus an in-order word model drives
// directed and randomized frames; define PERM_FEED_STALL_CNT_EN to also check stall_cnt.
module tb_perm_feed_tx;

  localparam int W     = 64;
  localparam int NLANE = 25;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stopin;
  logic         busy;
  logic         done;
  logic         pushout;
  logic         firstout;
  logic [2:0]   ax;
  logic [2:0]   ay;
  logic [W-1:0] rd;
  logic [W-1:0] dout;
`ifdef PERM_FEED_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  logic [W-1:0] mem [NLANE];
  int checks     = 0;
  int errors     = 0;
  int firstCount = 0;
  int doneCount  = 0;

  always #5 clk = ~clk;

  // Lane memory read port: combinational, lane (x,y) stored at index x+5*y.
  always_comb begin
    rd = '0;
    if (ax < 3'd5 && ay < 3'd5) rd = mem[int'(ay) * 5 + int'(ax)];
  end

  perm_feed_tx #(.W(W), .NLANE(NLANE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ax       (ax),
    .ay       (ay),
    .rd       (rd),
    .pushout  (pushout),
    .stopin   (stopin),
    .firstout (firstout),
`ifdef PERM_FEED_STALL_CNT_EN
    .dout     (dout),
    .stall_cnt(stall_cnt)
`else
    .dout     (dout)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic r);
    start  = s;
    stopin = st;
    reset  = r;
  endtask

  task automatic fillMem(input bit randomFill);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        mem[x + 5 * y] = randomFill ? {$urandom, $urandom} : 64'(256 * y + x);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_pushout"}, 64'(pushout), 64'(0));
    checkOutput({tag, "_firstout"}, 64'(firstout), 64'(0));
    checkOutput({tag, "_dout"}, dout, 64'(0));
    checkOutput({tag, "_ax"}, 64'(ax), 64'(0));
    checkOutput({tag, "_ay"}, 64'(ay), 64'(0));
`ifdef PERM_FEED_STALL_CNT_EN
    checkOutput({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
`endif
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_pushout", 64'(pushout), 64'(0));
      checkOutput("idle_busy", 64'(busy), 64'(0));
      checkOutput("idle_done", 64'(done), 64'(0));
      @(posedge clk);
    end
  endtask

  // mode 0: no stall; 1: stopin on cycles 4..4+stallLen-1; 2: random stopin; 3: reset at cycle 12.
  // Cycle 0 is the start cycle. The model: words are mem[0..24] in order, word k is valid from
  // cycle 2 onward until accepted, and the next lane read targets index accepted+1.
  task automatic sendFrame(input int mode, input bit extraStart, input int stallLen);
    int  accepted, lastAccept, stalls, n, bound;
    bit  fin, s, st, r, modelPush;
    accepted   = 0;
    lastAccept = -10;
    stalls     = 0;
    fin        = 1'b0;
    bound      = 400 + stallLen;
    @(negedge clk);
    checkOutput("start_busy", 64'(busy), 64'(0));
    checkOutput("start_done", 64'(done), 64'(0));
    checkOutput("start_pushout", 64'(pushout), 64'(0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    for (int c = 1; c < bound && !fin; c++) begin
      @(negedge clk);
      case (mode)
        1:       st = (c >= 4) && (c < 4 + stallLen);
        2:       st = 1'($urandom_range(0, 1));
        default: st = 1'b0;
      endcase
      s = extraStart && (c == 10);
      r = (mode == 3) && (c == 12);
      if (mode == 3 && c == 13) begin
        checkResetValues("abort");
        s   = 1'b0;
        fin = 1'b1;
      end else if (accepted == NLANE && c == lastAccept + 1) begin
        checkOutput("done_pulse", 64'(done), 64'(1));
        checkOutput("done_busy", 64'(busy), 64'(0));
        checkOutput("done_pushout", 64'(pushout), 64'(0));
        checkOutput("done_cycle", 64'(c), 64'(27 + stalls));
`ifdef PERM_FEED_STALL_CNT_EN
        checkOutput("stall_cnt", 64'(stall_cnt), 64'((stalls > 65535) ? 65535 : stalls));
`endif
        if (done === 1'b1) doneCount++;
        s   = extraStart;
        fin = 1'b1;
      end else begin
        modelPush = (c >= 2);
        checkOutput("busy", 64'(busy), 64'(1));
        checkOutput("done_early", 64'(done), 64'(0));
        checkOutput("pushout", 64'(pushout), 64'(modelPush));
`ifdef PERM_FEED_STALL_CNT_EN
        if (c == 1) checkOutput("stall_cnt_clear", 64'(stall_cnt), 64'(0));
`endif
        if (modelPush) begin
          checkOutput("dout", dout, mem[accepted]);
          checkOutput("firstout", 64'(firstout), 64'(accepted == 0));
        end
        n = accepted + (modelPush ? 1 : 0);
        if (n < NLANE) begin
          checkOutput("ax", 64'(ax), 64'(n % 5));
          checkOutput("ay", 64'(ay), 64'(n / 5));
        end
        if (modelPush && st) stalls++;
        if (modelPush && !st) begin
          if (firstout === 1'b1) firstCount++;
          accepted++;
          lastAccept = c;
        end
      end
      applyStimulus(s, st, r);
      @(posedge clk);
    end
    if (!fin) checkOutput("frame_timeout", 64'(0), 64'(1));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int f0, d0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    fillMem(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    idleCycles(2);

    $display("[TB] basic frame");
    sendFrame(0, 1'b0, 0);
    idleCycles(2);

    $display("[TB] backpressure on cycles T+4..T+7");
    sendFrame(1, 1'b0, 4);
    idleCycles(1);

    $display("[TB] three back-to-back frames with random stopin");
    f0 = firstCount;
    d0 = doneCount;
    for (int i = 0; i < 3; i++) begin
      fillMem(1'b1);
      sendFrame(2, 1'b0, 0);
    end
    checkOutput("first_pulses", 64'(firstCount - f0), 64'(3));
    checkOutput("done_pulses", 64'(doneCount - d0), 64'(3));

    $display("[TB] start during busy and coincident with done");
    fillMem(1'b0);
    sendFrame(0, 1'b1, 0);
    fillMem(1'b1);
    sendFrame(0, 1'b0, 0);
    idleCycles(2);

    $display("[TB] reset mid-frame");
    d0 = doneCount;
    fillMem(1'b0);
    sendFrame(3, 1'b0, 0);
    idleCycles(3);
    checkOutput("abort_no_done", 64'(doneCount - d0), 64'(0));
    sendFrame(0, 1'b0, 0);
    idleCycles(1);

`ifdef PERM_FEED_STALL_CNT_EN
    $display("[TB] long stall saturates stall_cnt");
    sendFrame(1, 1'b0, 70000);
    idleCycles(1);
    sendFrame(0, 1'b0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
